score_tracker: RTL and testbench
================================

Name: score_tracker

Overview:
- Producer end of the score interface consumed by the score display: it accumulates point events from the game logic and drives the `score` word and the `new_score` strobe.
- Saturates the score at the 4-digit display limit and tracks the session high score.
- Rate-limits `new_score` strobes so the downstream sequential binary-to-BCD converter always finishes before it is restarted.
- Sits between the egg/collision logic and the score display.

Parameters:
- SCORE_W, 14, width of score and high_score.
- MAX_SCORE, 9999, saturation ceiling (largest 4-digit BCD value).
- PTS_W, 4, width of add_points.
- HOLDOFF, 16, minimum cycles between new_score strobes. Must be at least the converter latency; legal range 2..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- game_reset  in  1  synchronous clear of the running score; high score is kept.
- add_valid  in  1  point event qualifier, sampled every clk edge.
- add_points  in  PTS_W  points to add when add_valid=1.
- score  out  SCORE_W  registered snapshot presented to the display; changes only on strobe edges.
- new_score  out  1  one-cycle start strobe to the BCD converter; score is valid in the same cycle.
- high_score  out  SCORE_W  largest snapshot issued since reset.
- new_high  out  1  one-cycle pulse, coincident with new_score, when high_score updates.
- saturated  out  1  high while the internal accumulator equals MAX_SCORE.

Behaviour:
- Reset (reset=0, asynchronous):
  - acc, score and high_score are 0.
  - pending=0, hold_cnt=0, state=IDLE.
  - new_score, new_high and saturated are 0.
  - Assertion mid-holdoff aborts the holdoff immediately.
- Accumulator acc (SCORE_W bits, internal):
  - On add_valid=1: acc <= min(acc + add_points, MAX_SCORE). The sum is computed at SCORE_W+1 bits so it cannot wrap.
  - game_reset=1: acc <= 0. This has priority over add_valid in the same cycle.
- pending flag:
  - Set at the same edge that acc takes a value different from its old value, or on any game_reset.
  - add_points=0, or adding while already saturated, leaves acc unchanged and does not set pending.
  - Cleared at a strobe edge unless acc changes at that same edge; a change at the strobe edge keeps pending=1.
- Strobe FSM, states IDLE and HOLD:
  - IDLE, pending=1: strobe edge, then go to HOLD with hold_cnt <= HOLDOFF-1.
  - IDLE, pending=0: stay in IDLE.
  - HOLD, hold_cnt>0: hold_cnt decrements.
  - HOLD, hold_cnt=0, pending=1: strobe edge, reload hold_cnt, stay in HOLD.
  - HOLD, hold_cnt=0, pending=0: go to IDLE.
- Strobe edge actions:
  - score <= acc (the value after any same-edge update is excluded; the registered acc is used).
  - new_score is 1 for exactly one cycle.
  - If acc > high_score: high_score <= acc and new_high is 1 for that same cycle.
- Latency:
  - An event sampled at edge k with the FSM in IDLE produces a strobe at edge k+1.
  - Under continuous events, strobes are spaced exactly HOLDOFF cycles apart.
  - Events arriving during HOLD coalesce into one strobe that carries the latest acc.
- saturated is registered: saturated <= (acc_next == MAX_SCORE).
- score is never modified outside strobe edges, so the converter input is stable for the whole holdoff.

Decomposition:
- Shared package holds:
  - SCORE_W and MAX_SCORE, shared with the display and BCD converter.
  - The FSM state enum {IDLE, HOLD}.
- No sub-module is warranted. The saturating adder is one small function or expression inside this block.

Test Plan:
- Release reset, idle for 5 cycles: score=0, high_score=0, new_score never asserts.
- Single event add_points=3 at edge k: new_score=1 at edge k+1 only, with score=3, high_score=3, new_high=1.
- add_valid held high with add_points=1 for 40 cycles starting from IDLE:
  - Strobes at edges k+1, k+17 and k+33, each exactly 16 cycles apart.
  - Each strobe presents the current acc: 1, 17, 33.
  - A final strobe follows once the holdoff expires, with score=40.
- Preload acc=9995, then add_points=9: score=9999 and saturated=1. A further add_points=5 produces no new_score.
- Score 50, then game_reset together with add_valid=1, add_points=7:
  - Strobe gives score=0 (game_reset wins).
  - high_score stays 50; new_high=0.
- Assert reset mid-HOLD with pending=1:
  - All outputs go to 0 immediately.
  - After release, no strobe until a new event.

Source files
------------

// File: rtl/score_tracker_pkg.sv
// Shared definitions for the score path: score width, display ceiling and strobe FSM states.
// Imported by the tracker; the display and BCD converter use the same width and ceiling.
package score_tracker_pkg;

  localparam int unsigned SCORE_W   = 14;
  localparam int unsigned MAX_SCORE = 9999;
  localparam int unsigned HOLD_W    = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

endpackage

// File: rtl/score_tracker.sv
// Accumulates point events into a saturating score and issues rate-limited snapshot strobes
// to the sequential BCD converter, tracking the session high score alongside.
module score_tracker #(
  parameter int unsigned SCORE_W   = score_tracker_pkg::SCORE_W,
  parameter int unsigned MAX_SCORE = score_tracker_pkg::MAX_SCORE,
  parameter int unsigned PTS_W     = 4,
  parameter int unsigned HOLDOFF   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_reset,
  input  logic               add_valid,
  input  logic [PTS_W-1:0]   add_points,
  output logic [SCORE_W-1:0] score,
  output logic               new_score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               saturated
);
  import score_tracker_pkg::*;

  localparam logic [SCORE_W-1:0] MaxVal  = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W:0]   MaxWide = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [HOLD_W-1:0]  Reload  = HOLD_W'(HOLDOFF - 1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0]  acc_q, acc_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic                pending_q, pending_d;
  logic                new_score_q, new_high_q, saturated_q;
  logic                new_high_d, saturated_d;
  logic                strobe;
  logic [SCORE_W:0]    sum;

  // Extra sum bit keeps the comparison against the ceiling wrap-free.
  always_comb begin
    sum   = {1'b0, acc_q} + {{(SCORE_W + 1 - PTS_W){1'b0}}, add_points};
    acc_d = acc_q;
    if (game_reset) begin
      acc_d = '0;
    end else if (add_valid) begin
      acc_d = (sum > MaxWide) ? MaxVal : sum[SCORE_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    strobe  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q) begin
          strobe  = 1'b1;
          state_d = StHold;
          hold_d  = Reload;
        end
      end
      StHold: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (pending_q) begin
          strobe = 1'b1;
          hold_d = Reload;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A change landing on the strobe edge is not in the snapshot, so it must stay pending.
  always_comb begin
    pending_d = pending_q;
    if (game_reset || (acc_d != acc_q)) begin
      pending_d = 1'b1;
    end else if (strobe) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    score_d     = score_q;
    high_d      = high_q;
    new_high_d  = 1'b0;
    saturated_d = (acc_d == MaxVal);
    if (strobe) begin
      score_d = acc_q;
      if (acc_q > high_q) begin
        high_d     = acc_q;
        new_high_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      acc_q       <= '0;
      score_q     <= '0;
      high_q      <= '0;
      pending_q   <= 1'b0;
      new_score_q <= 1'b0;
      new_high_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      acc_q       <= acc_d;
      score_q     <= score_d;
      high_q      <= high_d;
      pending_q   <= pending_d;
      new_score_q <= strobe;
      new_high_q  <= new_high_d;
      saturated_q <= saturated_d;
    end
  end

  assign score      = score_q;
  assign new_score  = new_score_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;
  assign saturated  = saturated_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: reset, latency, holdoff spacing, saturation,
// game reset priority and asynchronous reset during holdoff.
module tb_score_tracker;

  localparam int unsigned SCORE_W = 14;
  localparam int unsigned PTS_W   = 4;
  localparam int unsigned HOLDOFF = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               game_reset = 1'b0;
  logic               add_valid = 1'b0;
  logic [PTS_W-1:0]   add_points = '0;
  logic [SCORE_W-1:0] score;
  logic               new_score;
  logic [SCORE_W-1:0] high_score;
  logic               new_high;
  logic               saturated;

  int errors = 0;
  int checks = 0;

  score_tracker #(
    .SCORE_W  (SCORE_W),
    .MAX_SCORE(9999),
    .PTS_W    (PTS_W),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .game_reset(game_reset),
    .add_valid (add_valid),
    .add_points(add_points),
    .score     (score),
    .new_score (new_score),
    .high_score(high_score),
    .new_high  (new_high),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    game_reset = 1'b0;
    add_valid  = 1'b0;
    add_points = '0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_strobe(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (new_score) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      quiet = new_score ? 0 : quiet + 1;
      if (quiet >= int'(HOLDOFF) + 2) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain: strobes never stopped within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    int strobes = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      if (new_score) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL reset_strobe: got %0d strobes, want 0", strobes);
    end
    checks++;
    if (score !== '0) begin
      errors++; $display("FAIL reset_score: got %0d, want 0", score);
    end
    checks++;
    if (high_score !== '0) begin
      errors++; $display("FAIL reset_high: got %0d, want 0", high_score);
    end
    checks++;
    if ({new_high, saturated} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b, want 00", {new_high, saturated});
    end
  endtask

  task automatic test_single();
    apply_reset();
    add_valid  = 1'b1;
    add_points = 4'd3;
    step();
    add_valid = 1'b0;
    checks++;
    if (new_score !== 1'b0) begin
      errors++; $display("FAIL single_early: new_score=%b at edge k, want 0", new_score);
    end
    step();
    checks++;
    if ({new_score, new_high} !== 2'b11) begin
      errors++; $display("FAIL single_strobe: {new_score,new_high}=%b, want 11", {new_score, new_high});
    end
    checks++;
    if (score !== 14'd3 || high_score !== 14'd3) begin
      errors++; $display("FAIL single_value: score=%0d high=%0d, want 3 3", score, high_score);
    end
    step();
    checks++;
    if ({new_score, new_high} !== 2'b00) begin
      errors++; $display("FAIL single_pulse: {new_score,new_high}=%b, want 00", {new_score, new_high});
    end
  endtask

  task automatic test_continuous();
    logic [SCORE_W-1:0] exp_score = '0;
    bit exp_strobe;
    apply_reset();
    add_points = 4'd1;
    for (int c = 0; c < 60; c++) begin
      add_valid = (c < 40);
      step();
      exp_strobe = (c == 1) || (c == 17) || (c == 33) || (c == 49);
      if (exp_strobe) exp_score = (c < 40) ? SCORE_W'(c) : 14'd40;
      checks++;
      if (new_score !== exp_strobe || score !== exp_score) begin
        errors++;
        $display("FAIL cont_edge%0d: new_score=%b score=%0d, want %b %0d",
                 c, new_score, score, exp_strobe, exp_score);
      end
    end
    add_valid = 1'b0;
  endtask

  task automatic test_saturation();
    bit got;
    int strobes = 0;
    apply_reset();
    add_valid  = 1'b1;
    add_points = 4'd15;
    for (int i = 0; i < 666; i++) step();
    add_points = 4'd5;
    step();
    add_valid = 1'b0;
    drain("sat_preload");
    checks++;
    if (score !== 14'd9995 || saturated !== 1'b0) begin
      errors++; $display("FAIL sat_preload: score=%0d sat=%b, want 9995 0", score, saturated);
    end
    add_valid  = 1'b1;
    add_points = 4'd9;
    step();
    add_valid = 1'b0;
    checks++;
    if (saturated !== 1'b1) begin
      errors++; $display("FAIL sat_flag: saturated=%b, want 1", saturated);
    end
    wait_strobe(got);
    checks++;
    if (!got || score !== 14'd9999) begin
      errors++; $display("FAIL sat_value: strobe=%b score=%0d, want 1 9999", got, score);
    end
    drain("sat_settle");
    add_valid  = 1'b1;
    add_points = 4'd5;
    step();
    add_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (new_score) strobes++;
    end
    checks++;
    if (strobes !== 0 || score !== 14'd9999 || saturated !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: strobes=%0d score=%0d sat=%b, want 0 9999 1",
               strobes, score, saturated);
    end
  endtask

  task automatic test_game_reset();
    bit got;
    apply_reset();
    add_valid  = 1'b1;
    add_points = 4'd15;
    for (int i = 0; i < 3; i++) step();
    add_points = 4'd5;
    step();
    add_valid = 1'b0;
    drain("game_preload");
    checks++;
    if (score !== 14'd50 || high_score !== 14'd50) begin
      errors++; $display("FAIL game_preload: score=%0d high=%0d, want 50 50", score, high_score);
    end
    game_reset = 1'b1;
    add_valid  = 1'b1;
    add_points = 4'd7;
    step();
    game_reset = 1'b0;
    add_valid  = 1'b0;
    wait_strobe(got);
    checks++;
    if (!got || score !== '0) begin
      errors++; $display("FAIL game_score: strobe=%b score=%0d, want 1 0", got, score);
    end
    checks++;
    if (high_score !== 14'd50 || new_high !== 1'b0) begin
      errors++; $display("FAIL game_high: high=%0d new_high=%b, want 50 0", high_score, new_high);
    end
  endtask

  task automatic test_reset_mid_hold();
    bit got;
    int strobes = 0;
    apply_reset();
    add_valid  = 1'b1;
    add_points = 4'd3;
    step();
    add_valid = 1'b0;
    step();
    add_valid  = 1'b1;
    add_points = 4'd2;
    step();
    add_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({score, high_score, new_score, new_high, saturated} !== '0) begin
      errors++;
      $display("FAIL async_reset: score=%0d high=%0d ns=%b nh=%b sat=%b, want all 0",
               score, high_score, new_score, new_high, saturated);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (new_score) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL post_reset_quiet: strobes=%0d, want 0", strobes);
    end
    add_valid  = 1'b1;
    add_points = 4'd4;
    step();
    add_valid = 1'b0;
    wait_strobe(got);
    checks++;
    if (!got || score !== 14'd4 || high_score !== 14'd4) begin
      errors++; $display("FAIL post_reset_event: strobe=%b score=%0d high=%0d, want 1 4 4",
                         got, score, high_score);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_saturation();
    test_game_reset();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
